// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the 64-bit data-memory bus.
// Accepts one load/store at a time, waits LATENCY cycles, then completes the
// access against an internal DEPTH x 64-bit array with a one-cycle ack.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned accesses complete with err=1, no write, rdata=0
//   undefined -> address bits below the access size are forced to zero
module dmem_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req,
  input  logic        we,
  input  logic [63:0] addr,
  input  logic [1:0]  size,
  input  logic [63:0] wdata,
  output logic        ack,
  output logic [63:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r, next_state_s;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [63:0] addr_r;
  logic [1:0]  size_r;
  logic [63:0] wdata_r;
  logic [63:0] mem [DEPTH];

  logic        acc_we_s;
  logic [63:0] acc_addr_s;
  logic [1:0]  acc_size_s;
  logic [63:0] acc_wdata_s;
  logic [2:0]  low_mask_s;
  logic [2:0]  offset_s;
  logic        misalign_s;
  logic        oor_s;
  logic        fault_s;
  logic [AW-1:0] idx_s;
  logic [63:0] word_s;
  logic [63:0] load_s;
  logic [63:0] wmask_s;
  logic [63:0] wnew_s;
  logic        commit_s;

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] size_low_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_low_mask = 3'b000;
      2'b01:   size_low_mask = 3'b001;
      2'b10:   size_low_mask = 3'b011;
      2'b11:   size_low_mask = 3'b111;
      default: size_low_mask = 3'b111;
    endcase
  endfunction

  // LSB-aligned bit mask covering the bytes of an access of this size.
  function automatic logic [63:0] size_data_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_data_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_data_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_data_mask = 64'h0000_0000_FFFF_FFFF;
      2'b11:   size_data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default: size_data_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Access source: live inputs when accepting from IDLE (needed for LATENCY=0), captured copy otherwise.
  always_comb begin
    if (state_r == IDLE) begin
      acc_we_s    = we;
      acc_addr_s  = addr;
      acc_size_s  = size;
      acc_wdata_s = wdata;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_size_s  = size_r;
      acc_wdata_s = wdata_r;
    end
  end

  // Address decode, fault detection and load/store data path.
  always_comb begin
    low_mask_s = size_low_mask(acc_size_s);
    misalign_s = |(acc_addr_s[2:0] & low_mask_s);
    offset_s   = acc_addr_s[2:0] & ~low_mask_s;
    idx_s      = acc_addr_s[3 +: AW];
    oor_s      = |acc_addr_s[63:AW+3];
`ifdef DMEM_MISALIGN_TRAP_EN
    fault_s    = oor_s | misalign_s;
`else
    fault_s    = oor_s;
`endif
    word_s     = mem[idx_s];
    load_s     = (word_s >> {offset_s, 3'b000}) & size_data_mask(acc_size_s);
    wmask_s    = size_data_mask(acc_size_s) << {offset_s, 3'b000};
    wnew_s     = (word_s & ~wmask_s) | ((acc_wdata_s << {offset_s, 3'b000}) & wmask_s);
  end

  // Next-state logic; the access commits on the edge that enters RESP.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          next_state_s = (LATENCY == 0) ? RESP : WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          next_state_s = RESP;
        end else begin
          next_state_s = WAIT;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
    commit_s = (next_state_s == RESP) && RST;
  end

  // State, counter, request capture and registered response outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 64'd0;
      size_r  <= 2'd0;
      wdata_r <= 64'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= 64'd0;
    end else begin
      state_r <= next_state_s;
      if (state_r == IDLE && req) begin
        we_r    <= we;
        addr_r  <= addr;
        size_r  <= size;
        wdata_r <= wdata;
        cnt_r   <= 4'(LATENCY);
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end
      ack <= commit_s;
      if (commit_s) begin
        err <= fault_s;
        if (fault_s) begin
          rdata <= 64'd0;
        end else if (!acc_we_s) begin
          rdata <= load_s;
        end
      end else begin
        err <= 1'b0;
      end
    end
  end

  // Storage array write port; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (commit_s && acc_we_s && !fault_s) begin
      mem[idx_s] <= wnew_s;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (DEPTH=512; one instance with
// LATENCY=2, one with LATENCY=0). Honors DMEM_MISALIGN_TRAP_EN for expectations.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [63:0] addr, wdata;
  logic [1:0]  size;
  logic        ack, err;
  logic [63:0] rdata;

  logic        req0, we0;
  logic [63:0] addr0, wdata0;
  logic [1:0]  size0;
  logic        ack0, err0;
  logic [63:0] rdata0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(512), .LATENCY(LAT)) u_dut (
    .CLK(clk), .RST(rst_n), .req(req), .we(we), .addr(addr), .size(size),
    .wdata(wdata), .ack(ack), .rdata(rdata), .err(err)
  );

  dmem_responder #(.DEPTH(512), .LATENCY(0)) u_dut0 (
    .CLK(clk), .RST(rst_n), .req(req0), .we(we0), .addr(addr0), .size(size0),
    .wdata(wdata0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // One access on the LATENCY=2 instance; scrambles addr/wdata after acceptance.
  task automatic access(input logic w, input logic [63:0] a, input logic [1:0] s,
                        input logic [63:0] d, input string tag,
                        input logic [63:0] exp_rdata, input logic exp_err);
    int n;
    req = 1'b1; we = w; addr = a; size = s; wdata = d;
    @(posedge clk); #1;
    addr = ~a; wdata = ~d; we = ~w;
    n = 0;
    while (!ack && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    check_val({tag, " latency"}, 64'(n), 64'(LAT));
    check_val({tag, " err"}, {63'd0, err}, {63'd0, exp_err});
    check_val({tag, " rdata"}, rdata, exp_rdata);
    @(posedge clk); #1;
    check_val({tag, " ack pulse"}, {63'd0, ack}, 64'd0);
    check_val({tag, " err clear"}, {63'd0, err}, 64'd0);
  endtask

  initial begin
    int n_ack;
    int viol;
    logic prev;
    logic [63:0] mis_rdata;
    logic        mis_err;

    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = 64'd0; size = 2'd0; wdata = 64'd0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 64'd0; size0 = 2'd0; wdata0 = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset ack", {63'd0, ack}, 64'd0);
    check_val("reset err", {63'd0, err}, 64'd0);
    check_val("reset rdata", rdata, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b1, 64'h40, 2'b11, 64'h1122334455667788, "st d40", 64'd0, 1'b0);
    access(1'b0, 64'h40, 2'b11, 64'd0, "ld d40", 64'h1122334455667788, 1'b0);
    access(1'b1, 64'h43, 2'b00, 64'hFFFF_FFFF_FFFF_FFAA, "st b43", 64'h1122334455667788, 1'b0);
    access(1'b0, 64'h40, 2'b11, 64'd0, "ld d40 merged", 64'h11223344AA667788, 1'b0);
    access(1'b0, 64'h42, 2'b01, 64'd0, "ld h42", 64'h000000000000AA66, 1'b0);
    access(1'b0, 64'h1000, 2'b11, 64'd0, "ld oor", 64'd0, 1'b1);
    access(1'b0, 64'h42, 2'b01, 64'd0, "ld h42 again", 64'h000000000000AA66, 1'b0);
    access(1'b1, 64'h48, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, "st d48", 64'h000000000000AA66, 1'b0);
    access(1'b1, 64'h4C, 2'b10, 64'hDEAD_BEEF_0123_4567, "st w4c", 64'h000000000000AA66, 1'b0);
    access(1'b1, 64'h4A, 2'b01, 64'h0000_0000_0000_BEEF, "st h4a", 64'h000000000000AA66, 1'b0);
    access(1'b0, 64'h48, 2'b11, 64'd0, "ld d48", 64'h01234567BEEFFFFF, 1'b0);
    access(1'b0, 64'h4D, 2'b00, 64'd0, "ld b4d", 64'h0000000000000045, 1'b0);

`ifdef DMEM_MISALIGN_TRAP_EN
    mis_rdata = 64'd0;
    mis_err   = 1'b1;
`else
    mis_rdata = 64'h00000000AA667788;
    mis_err   = 1'b0;
`endif
    access(1'b0, 64'h42, 2'b10, 64'd0, "ld w42 misaligned", mis_rdata, mis_err);

    access(1'b1, 64'hFF8, 2'b11, 64'h5A5A_0123_4567_A5A5, "st d ff8", mis_rdata, 1'b0);
    access(1'b0, 64'hFF8, 2'b11, 64'd0, "ld d ff8", 64'h5A5A_0123_4567_A5A5, 1'b0);
    access(1'b0, 64'h8000_0000_0000_0040, 2'b11, 64'd0, "ld high addr", 64'd0, 1'b1);
    access(1'b1, 64'h0, 2'b11, 64'h0F0E_0D0C_0B0A_0908, "st d0", 64'd0, 1'b0);
    access(1'b1, 64'h1000, 2'b11, 64'hFFFF_0000_FFFF_0000, "st oor", 64'd0, 1'b1);
    access(1'b0, 64'h0, 2'b11, 64'd0, "ld d0", 64'h0F0E_0D0C_0B0A_0908, 1'b0);

    // Reset during WAIT of a store: store must be dropped and no ack issued.
    access(1'b1, 64'h80, 2'b11, 64'hCAFE_F00D_1234_5678, "st d80", 64'h0F0E_0D0C_0B0A_0908, 1'b0);
    req = 1'b1; we = 1'b1; addr = 64'h80; size = 2'b11; wdata = 64'h0BAD_0BAD_0BAD_0BAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("mid wait ack", {63'd0, ack}, 64'd0);
    rst_n = 1'b0;
    #1;
    check_val("mid rst ack", {63'd0, ack}, 64'd0);
    check_val("mid rst rdata", rdata, 64'd0);
    req = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_val("in rst ack", {63'd0, ack}, 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post rst ack", {63'd0, ack}, 64'd0);
    access(1'b0, 64'h80, 2'b11, 64'd0, "ld d80 after rst", 64'hCAFE_F00D_1234_5678, 1'b0);

    // LATENCY=0 with req held high: one ack every second cycle.
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'h10; size0 = 2'b11; wdata0 = 64'h7766554433221100;
    n_ack = 0; viol = 0; prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack0) n_ack++;
      if (ack0 && prev) viol++;
      prev = ack0;
    end
    req0 = 1'b0;
    check_val("lat0 ack count", 64'(n_ack), 64'd10);
    check_val("lat0 back-to-back acks", 64'(viol), 64'd0);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10; size0 = 2'b11; wdata0 = 64'd0;
    @(posedge clk); #1;
    req0 = 1'b0;
    check_val("lat0 ld ack", {63'd0, ack0}, 64'd1);
    check_val("lat0 ld rdata", rdata0, 64'h7766554433221100);
    check_val("lat0 ld err", {63'd0, err0}, 64'd0);
    @(posedge clk); #1;
    check_val("lat0 ack pulse", {63'd0, ack0}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
